ib8_arbiter: RTL and testbench
==============================

Name: ib8_arbiter

Overview:
- Packet-granular round-robin arbiter that merges PORTS 8-bit Internal Bus streams (SOF_N/EOF_N/SRC_RDY_N/DST_RDY_N framing) onto one 8-bit Internal Bus output.
- Sits in front of a shared IB8 consumer such as a transformer or endpoint.
- Once a port is granted, it holds the bus until its EOF word transfers, so packets never interleave on the output.

Parameters:
- PORTS, 4: number of input streams, legal range 2..8.
- CNT_WIDTH, 16: width of each per-port packet counter (optional feature only).

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- RX_DATA  in  PORTS*8  input data; port i occupies bits [8*i+7:8*i].
- RX_SOF_N  in  PORTS  start of packet per port, active low.
- RX_EOF_N  in  PORTS  end of packet per port, active low.
- RX_SRC_RDY_N  in  PORTS  source ready per port, active low.
- RX_DST_RDY_N  out  PORTS  destination ready per port, active low.
- TX_DATA  out  8  merged data.
- TX_SOF_N  out  1  merged SOF, active low.
- TX_EOF_N  out  1  merged EOF, active low.
- TX_SRC_RDY_N  out  1  merged source ready, active low.
- TX_DST_RDY_N  in  1  downstream destination ready, active low.
- GRANT  out  PORTS  one-hot grant, valid in BUSY, all zeros in IDLE.

Behaviour:
- Reset (async assert, sync deassert inside block):
  - state=IDLE, GRANT=0, last_grant=PORTS-1, so port 0 has highest priority first.
  - RX_DST_RDY_N all 1; TX_SRC_RDY_N=1, TX_SOF_N=1, TX_EOF_N=1, TX_DATA=0.
- Request of port i: req[i] = !RX_SRC_RDY_N[i] && !RX_SOF_N[i]. A port offering a non-SOF word while not granted is not a request; it is held with RX_DST_RDY_N[i]=1.
- State IDLE:
  - All RX_DST_RDY_N = 1. TX_SRC_RDY_N = 1.
  - If any req: pick the first requesting index scanning last_grant+1, last_grant+2, ... modulo PORTS.
  - Register GRANT=onehot(winner), last_grant=winner, go to BUSY.
  - Arbitration costs exactly one cycle; the SOF word is transferred no earlier than the cycle after the request is seen.
- State BUSY, granted port g:
  - TX_DATA, TX_SOF_N, TX_EOF_N, TX_SRC_RDY_N are combinational pass-through of port g.
  - RX_DST_RDY_N[g] = TX_DST_RDY_N; all other RX_DST_RDY_N = 1. Zero added latency in BUSY.
  - Transfer = !TX_SRC_RDY_N && !TX_DST_RDY_N.
  - On a transfer with !RX_EOF_N[g]: go to IDLE and clear GRANT on the next edge.
  - SOF and EOF in the same word is tolerated: a one-word packet, return to IDLE.
- Back-to-back: a minimum of one IDLE cycle between consecutive output packets. Max throughput per packet of L words is L/(L+1).
- Stalls: SRC_RDY_N or DST_RDY_N deasserted mid-packet keeps BUSY indefinitely; no timeout.
- A new request arriving during BUSY is queued implicitly (the source holds its word) and is evaluated in the next IDLE.
- Fairness: with all ports continuously requesting, grants rotate 0,1,2,...,PORTS-1,0. No port waits more than PORTS-1 packets.
- RESET_N asserted mid-packet: immediate return to IDLE, outputs forced to reset values; the partial packet is truncated. Upstream and downstream are reset by the same signal.
- Outputs in IDLE are driven inactive regardless of RX inputs: no glitch-through of SOF/EOF.

Optional Feature:
- Macro: IB8_ARBITER_PKT_CNT_EN.
- Defined:
  - Adds ports CNT_CLR (in, 1) and PKT_CNT (out, PORTS*CNT_WIDTH).
  - Counter i increments on each EOF transfer from port i and saturates at all-ones.
  - CNT_CLR=1 zeroes all counters synchronously; clear wins over a simultaneous increment.
  - Counters reset to 0 on RESET_N.
- Not defined: neither port exists and no counter logic is generated; arbitration behaviour is identical either way.

Test Plan:
- Single port 2, 4-word packet, TX_DST_RDY_N=0: port 2 SOF at cycle 0 -> GRANT=0100 at cycle 1; TX words at cycles 1-4 carry data 0x11,0x22,0x33,0x44 with SOF on the first and EOF on the last; IDLE at cycle 5.
- All 4 ports request simultaneously after reset, 3-word packets -> output packet order 0,1,2,3,0; each packet is followed by exactly one idle cycle.
- Port 1 granted, TX_DST_RDY_N=1 for 5 cycles mid-packet -> RX_DST_RDY_N[1]=1 during the stall; port 3's SOF stays un-acked; after EOF, port 3 wins with no word lost or duplicated.
- One-word packet (SOF_N=EOF_N=0) on port 0 -> one transfer, then IDLE; the next port-0 packet is granted two cycles after it.
- RESET_N pulsed low during word 2 of a 5-word packet -> all TX outputs inactive asynchronously; after release, GRANT=0 and port 0 is granted first.
- With IB8_ARBITER_PKT_CNT_EN and CNT_WIDTH=2: send 5 packets on port 1 -> PKT_CNT[1] saturates at 3; CNT_CLR asserted together with an EOF -> counter reads 0.

Source files
------------

// File: rtl/ib8_arbiter.sv
// Packet-granular round-robin arbiter merging PORTS IB8 streams onto one IB8 output.
// Optional per-port packet counters are built when IB8_ARBITER_PKT_CNT_EN is defined.
module ib8_arbiter #(
   parameter int PORTS     = 4,
   parameter int CNT_WIDTH = 16
) (
   input  logic                   CLK,
   input  logic                   RESET_N,
   input  logic [PORTS*8-1:0]     RX_DATA,
   input  logic [PORTS-1:0]       RX_SOF_N,
   input  logic [PORTS-1:0]       RX_EOF_N,
   input  logic [PORTS-1:0]       RX_SRC_RDY_N,
   output logic [PORTS-1:0]       RX_DST_RDY_N,
   output logic [7:0]             TX_DATA,
   output logic                   TX_SOF_N,
   output logic                   TX_EOF_N,
   output logic                   TX_SRC_RDY_N,
   input  logic                   TX_DST_RDY_N,
   output logic [PORTS-1:0]       GRANT
`ifdef IB8_ARBITER_PKT_CNT_EN
   ,
   input  logic                   CNT_CLR,
   output logic [PORTS*CNT_WIDTH-1:0] PKT_CNT
`endif
);

   localparam int   IDX_W      = $clog2(PORTS);
   localparam logic STATE_IDLE = 1'b0;
   localparam logic STATE_BUSY = 1'b1;

   logic [1:0]       rst_sync_q;
   logic             rst_n_int;
   logic             state_q, state_d;
   logic [PORTS-1:0] grant_q, grant_d;
   logic [IDX_W-1:0] last_q, last_d;
   logic [PORTS-1:0] req;
   logic             any_req;
   logic [IDX_W-1:0] winner;
   logic             busy;
   logic             xfer;
   logic             eof_xfer;

   // Reset asserts asynchronously, releases two edges after RESET_N rises.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         rst_sync_q <= 2'b00;
      end else begin
         rst_sync_q <= {rst_sync_q[0], 1'b1};
      end
   end

   assign rst_n_int = rst_sync_q[1];

   assign req  = ~RX_SRC_RDY_N & ~RX_SOF_N;
   assign busy = (state_q == STATE_BUSY);

   // Descending scan so the index closest after last_q is the final (winning) write.
   always_comb begin
      int idx;
      idx     = 0;
      winner  = last_q;
      any_req = 1'b0;
      for (int k = PORTS; k >= 1; k--) begin
         idx = (int'(last_q) + k) % PORTS;
         if (req[idx]) begin
            winner  = IDX_W'(idx);
            any_req = 1'b1;
         end
      end
   end

   always_comb begin
      TX_DATA      = 8'h00;
      TX_SOF_N     = 1'b1;
      TX_EOF_N     = 1'b1;
      TX_SRC_RDY_N = 1'b1;
      for (int i = 0; i < PORTS; i++) begin
         if (busy && grant_q[i]) begin
            TX_DATA      = RX_DATA[8*i +: 8];
            TX_SOF_N     = RX_SOF_N[i];
            TX_EOF_N     = RX_EOF_N[i];
            TX_SRC_RDY_N = RX_SRC_RDY_N[i];
         end
      end
   end

   assign RX_DST_RDY_N = ~(grant_q & {PORTS{busy & ~TX_DST_RDY_N}});
   assign GRANT        = grant_q;
   assign xfer         = ~TX_SRC_RDY_N & ~TX_DST_RDY_N;
   assign eof_xfer     = xfer & ~TX_EOF_N;

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      if (state_q == STATE_IDLE) begin
         if (any_req) begin
            grant_d         = '0;
            grant_d[winner] = 1'b1;
            last_d          = winner;
            state_d         = STATE_BUSY;
         end
      end else begin
         if (eof_xfer) begin
            grant_d = '0;
            state_d = STATE_IDLE;
         end
      end
   end

   always_ff @(posedge CLK or negedge rst_n_int) begin
      if (!rst_n_int) begin
         state_q <= STATE_IDLE;
         grant_q <= '0;
         last_q  <= IDX_W'(PORTS - 1);
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
      end
   end

`ifdef IB8_ARBITER_PKT_CNT_EN
   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      return (&v) ? v : v + CNT_WIDTH'(1);
   endfunction

   logic [CNT_WIDTH-1:0] cnt_q [PORTS];
   logic [CNT_WIDTH-1:0] cnt_d [PORTS];

   // Clear takes priority over an EOF landing in the same cycle.
   always_comb begin
      for (int i = 0; i < PORTS; i++) begin
         cnt_d[i] = cnt_q[i];
         if (CNT_CLR) begin
            cnt_d[i] = '0;
         end else if (eof_xfer && grant_q[i]) begin
            cnt_d[i] = sat_inc(cnt_q[i]);
         end
      end
   end

   always_ff @(posedge CLK or negedge rst_n_int) begin
      if (!rst_n_int) begin
         for (int i = 0; i < PORTS; i++) cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < PORTS; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   always_comb begin
      PKT_CNT = '0;
      for (int i = 0; i < PORTS; i++) PKT_CNT[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q[i];
   end
`endif

endmodule

// File: tb/tb_ib8_arbiter.sv
// Self-checking bench for ib8_arbiter: vector table plus multi-cycle packet sequences.
module tb_ib8_arbiter;
   localparam int P = 4;

   logic         CLK = 1'b0;
   logic         RESET_N;
   logic [31:0]  RX_DATA;
   logic [3:0]   RX_SOF_N, RX_EOF_N, RX_SRC_RDY_N, RX_DST_RDY_N;
   logic [7:0]   TX_DATA;
   logic         TX_SOF_N, TX_EOF_N, TX_SRC_RDY_N, TX_DST_RDY_N;
   logic [3:0]   GRANT;
`ifdef IB8_ARBITER_PKT_CNT_EN
   logic         CNT_CLR;
   logic [7:0]   PKT_CNT;
`endif

   always #5 CLK = ~CLK;

   ib8_arbiter #(.PORTS(P), .CNT_WIDTH(2)) dut (
      .CLK(CLK), .RESET_N(RESET_N), .RX_DATA(RX_DATA), .RX_SOF_N(RX_SOF_N),
      .RX_EOF_N(RX_EOF_N), .RX_SRC_RDY_N(RX_SRC_RDY_N), .RX_DST_RDY_N(RX_DST_RDY_N),
      .TX_DATA(TX_DATA), .TX_SOF_N(TX_SOF_N), .TX_EOF_N(TX_EOF_N),
      .TX_SRC_RDY_N(TX_SRC_RDY_N), .TX_DST_RDY_N(TX_DST_RDY_N), .GRANT(GRANT)
`ifdef IB8_ARBITER_PKT_CNT_EN
      , .CNT_CLR(CNT_CLR), .PKT_CNT(PKT_CNT)
`endif
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  sof, eof, src;
      logic        txdst;
      logic [3:0]  grant, rxdst;
      logic        txsrc, txsof, txeof;
      logic [7:0]  txdata;
   } vec_t;
   vec_t vt [9];

   // Packet source model per port.
   int         s_left [P];
   int         s_len  [P];
   int         s_w    [P];
   logic [7:0] s_base [P];

   // Output monitor log.
   logic [7:0] m_data [64];
   logic       m_sof  [64];
   logic       m_eof  [64];
   int         m_cyc  [64];
   int         m_n;
   logic [3:0] g_log  [64];

   task automatic clear_sources();
      for (int p = 0; p < P; p++) begin
         s_left[p] = 0; s_len[p] = 1; s_w[p] = 0; s_base[p] = 8'h00;
      end
      m_n = 0;
   endtask

   task automatic drive_inputs();
      logic [31:0] d;
      logic [3:0]  sof, eof, src;
      d = '0; sof = 4'hF; eof = 4'hF; src = 4'hF;
      for (int p = 0; p < P; p++) begin
         if (s_left[p] > 0) begin
            src[p] = 1'b0;
            sof[p] = (s_w[p] != 0);
            eof[p] = (s_w[p] != s_len[p] - 1);
            d[8*p +: 8] = s_base[p] + 8'(s_w[p]);
         end
      end
      RX_DATA = d; RX_SOF_N = sof; RX_EOF_N = eof; RX_SRC_RDY_N = src;
   endtask

   task automatic do_reset();
      RESET_N = 1'b0;
      clear_sources();
      drive_inputs();
      TX_DST_RDY_N = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      check("rst_state", 32'({GRANT, RX_DST_RDY_N, TX_SRC_RDY_N, TX_SOF_N, TX_EOF_N, TX_DATA}),
            32'({4'h0, 4'hF, 3'b111, 8'h00}));
      @(negedge CLK);
      RESET_N = 1'b1;
      repeat (3) @(posedge CLK);
   endtask

   // Runs n cycles; TX_DST_RDY_N is high for cycles in [st_from, st_to).
   task automatic run(input int n, input int st_from, input int st_to);
      for (int c = 0; c < n; c++) begin
         @(posedge CLK);
         #1;
         drive_inputs();
         TX_DST_RDY_N = (c >= st_from && c < st_to);
         #4;
         g_log[c] = GRANT;
         if (TX_DST_RDY_N) check("stall_rxdst", 32'(RX_DST_RDY_N), 32'hF);
         if (!TX_SRC_RDY_N && !TX_DST_RDY_N && m_n < 64) begin
            m_data[m_n] = TX_DATA; m_sof[m_n] = TX_SOF_N; m_eof[m_n] = TX_EOF_N;
            m_cyc[m_n] = c; m_n++;
         end
         for (int p = 0; p < P; p++) begin
            if (s_left[p] > 0 && !RX_DST_RDY_N[p]) begin
               s_w[p]++;
               if (s_w[p] == s_len[p]) begin
                  s_w[p] = 0;
                  s_left[p]--;
               end
            end
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      int ord [5];
      ord = '{0, 1, 2, 3, 0};
`ifdef IB8_ARBITER_PKT_CNT_EN
      CNT_CLR = 1'b0;
`endif
      vt[0] = '{32'h0011_0000, 4'b1011, 4'hF, 4'b1011, 1'b0, 4'h0, 4'hF, 1'b1, 1'b1, 1'b1, 8'h00};
      vt[1] = '{32'h0011_0000, 4'b1011, 4'hF, 4'b1011, 1'b0, 4'b0100, 4'b1011, 1'b0, 1'b0, 1'b1, 8'h11};
      vt[2] = '{32'h0022_0000, 4'hF, 4'hF, 4'b1011, 1'b0, 4'b0100, 4'b1011, 1'b0, 1'b1, 1'b1, 8'h22};
      vt[3] = '{32'h0033_0000, 4'hF, 4'hF, 4'b1011, 1'b0, 4'b0100, 4'b1011, 1'b0, 1'b1, 1'b1, 8'h33};
      vt[4] = '{32'h0044_0000, 4'hF, 4'b1011, 4'b1011, 1'b0, 4'b0100, 4'b1011, 1'b0, 1'b1, 1'b0, 8'h44};
      vt[5] = '{32'h0000_0000, 4'hF, 4'hF, 4'hF, 1'b0, 4'h0, 4'hF, 1'b1, 1'b1, 1'b1, 8'h00};
      vt[6] = '{32'h0000_00EE, 4'hF, 4'hF, 4'b1110, 1'b0, 4'h0, 4'hF, 1'b1, 1'b1, 1'b1, 8'h00};
      vt[7] = '{32'h0000_00EE, 4'hF, 4'hF, 4'b1110, 1'b0, 4'h0, 4'hF, 1'b1, 1'b1, 1'b1, 8'h00};
      vt[8] = '{32'h0000_0000, 4'hF, 4'hF, 4'hF, 1'b0, 4'h0, 4'hF, 1'b1, 1'b1, 1'b1, 8'h00};

      do_reset();
      for (int i = 0; i < 9; i++) begin
         @(posedge CLK);
         #1;
         RX_DATA = vt[i].data; RX_SOF_N = vt[i].sof; RX_EOF_N = vt[i].eof;
         RX_SRC_RDY_N = vt[i].src; TX_DST_RDY_N = vt[i].txdst;
         #4;
         check($sformatf("vec%0d", i),
               32'({GRANT, RX_DST_RDY_N, TX_SRC_RDY_N, TX_SOF_N, TX_EOF_N, TX_DATA}),
               32'({vt[i].grant, vt[i].rxdst, vt[i].txsrc, vt[i].txsof, vt[i].txeof, vt[i].txdata}));
      end

      // All four ports request at once: order 0,1,2,3,0 with one idle cycle between packets.
      do_reset();
      for (int p = 0; p < P; p++) begin
         s_left[p] = 2; s_len[p] = 3; s_base[p] = 8'(p * 16);
      end
      run(21, 0, 0);
      check("fair_count", 32'(m_n >= 15), 32'd1);
      for (int k = 0; k < 15; k++) begin
         check($sformatf("fair_word%0d", k), 32'({m_data[k], m_sof[k], m_eof[k]}),
               32'({8'(ord[k/3] * 16 + k % 3), (k % 3) != 0, (k % 3) != 2}));
         check($sformatf("fair_cyc%0d", k), 32'(m_cyc[k]), 32'(1 + (k / 3) * 4 + k % 3));
      end

      // Port 1 stalled downstream mid-packet while port 3 waits with its SOF.
      do_reset();
      s_left[1] = 1; s_len[1] = 4; s_base[1] = 8'h10;
      s_left[3] = 1; s_len[3] = 3; s_base[3] = 8'h30;
      run(15, 3, 8);
      check("stall_grant", 32'(g_log[5]), 32'b0010);
      check("stall_count", 32'(m_n), 32'd7);
      for (int k = 0; k < 7; k++) begin
         logic [7:0] ed;
         ed = (k < 4) ? 8'(8'h10 + k) : 8'(8'h30 + k - 4);
         check($sformatf("stall_word%0d", k), 32'({m_data[k], m_sof[k], m_eof[k]}),
               32'({ed, !(k == 0 || k == 4), !(k == 3 || k == 6)}));
      end
      check("stall_p3_sof_cyc", 32'(m_cyc[4]), 32'd11);

      // One-word packets on port 0.
      do_reset();
      s_left[0] = 2; s_len[0] = 1; s_base[0] = 8'hA0;
      run(6, 0, 0);
      check("one_count", 32'(m_n), 32'd2);
      check("one_word0", 32'({m_data[0], m_sof[0], m_eof[0]}), 32'({8'hA0, 2'b00}));
      check("one_word1", 32'({m_data[1], m_sof[1], m_eof[1]}), 32'({8'hA0, 2'b00}));
      check("one_cyc0", 32'(m_cyc[0]), 32'd1);
      check("one_cyc1", 32'(m_cyc[1]), 32'd3);
      check("one_idle_grant", 32'(g_log[2]), 32'd0);

      // Reset pulse in the middle of a 5-word packet.
      do_reset();
      s_left[0] = 1; s_len[0] = 5; s_base[0] = 8'h50;
      run(4, 0, 0);
      check("mid_busy", 32'(GRANT), 32'b0001);
      RESET_N = 1'b0;
      #1;
      check("mid_rst_async", 32'({GRANT, RX_DST_RDY_N, TX_SRC_RDY_N, TX_SOF_N, TX_EOF_N, TX_DATA}),
            32'({4'h0, 4'hF, 3'b111, 8'h00}));
      do_reset();
      s_left[1] = 1; s_len[1] = 2; s_base[1] = 8'h60;
      s_left[0] = 1; s_len[0] = 2; s_base[0] = 8'h70;
      run(8, 0, 0);
      check("post_rst_grant0", 32'(g_log[0]), 32'd0);
      check("post_rst_grant1", 32'(g_log[1]), 32'b0001);
      check("post_rst_first", 32'({m_data[0], m_sof[0]}), 32'({8'h70, 1'b0}));

`ifdef IB8_ARBITER_PKT_CNT_EN
      do_reset();
      check("cnt_reset", 32'(PKT_CNT), 32'd0);
      s_left[1] = 5; s_len[1] = 1; s_base[1] = 8'h80;
      run(12, 0, 0);
      check("cnt_sat", 32'(PKT_CNT[3:2]), 32'd3);
      check("cnt_other", 32'(PKT_CNT[1:0]), 32'd0);
      CNT_CLR = 1'b1;
      s_left[1] = 1; s_len[1] = 2; s_base[1] = 8'h90;
      run(5, 0, 0);
      check("cnt_clr_wins", 32'(PKT_CNT[3:2]), 32'd0);
      check("cnt_clr_xfer", 32'(m_n), 32'd2);
      CNT_CLR = 1'b0;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
